// File: rtl/gate_sweep_pkg.sv
// gate_sweep_pkg
//   Shared constants for the gate sweep checker and the gate reference model.
//   - MODE_* : 3-bit reference function selectors, MODE_MAX is the highest legal one.
//   - ST_*   : sweep FSM state encoding (IDLE, DRIVE, SAMPLE, DONE).
package gate_sweep_pkg;

    localparam logic [2:0] MODE_AND  = 3'd0;
    localparam logic [2:0] MODE_OR   = 3'd1;
    localparam logic [2:0] MODE_NAND = 3'd2;
    localparam logic [2:0] MODE_NOR  = 3'd3;
    localparam logic [2:0] MODE_XOR  = 3'd4;
    localparam logic [2:0] MODE_XNOR = 3'd5;
    localparam logic [2:0] MODE_MAX  = MODE_XNOR;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_DRIVE  = 2'd1;
    localparam state_t ST_SAMPLE = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

endpackage

// File: rtl/gate_sweep_checker_ref.sv
// gate_ref_model
//   Combinational reference for an N_IN-input logic gate: given a function
//   selector and an input vector, produce the bit a correct gate would drive.
//   Every function is a reduction over all N_IN bits of the vector.
//   Ports:
//     mode_i  in  3     function selector (MODE_AND..MODE_XNOR)
//     vec_i   in  N_IN  gate input vector
//     exp_o   out 1     expected gate output (0 for unused selectors)
module gate_ref_model
    import gate_sweep_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  logic [2:0]      mode_i,
    input  logic [N_IN-1:0] vec_i,
    output logic            exp_o
);

    // Pure reduction per selector; selectors above MODE_MAX never reach a
    // comparison because the checker refuses to start with them.
    always_comb begin
        exp_o = 1'b0;
        case (mode_i)
            MODE_AND:  exp_o =  (&vec_i);
            MODE_OR:   exp_o =  (|vec_i);
            MODE_NAND: exp_o = ~(&vec_i);
            MODE_NOR:  exp_o = ~(|vec_i);
            MODE_XOR:  exp_o =  (^vec_i);
            MODE_XNOR: exp_o = ~(^vec_i);
            default:   exp_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker
//   Sweeps all 2^N_IN input vectors of a gate under test in ascending order,
//   holds each for DWELL cycles, then samples the gate output for one cycle
//   and compares it with the selected reference function. Mismatches are
//   counted in a saturating counter.
//   Ports:
//     clk_i        in   1      rising-edge clock
//     rst_ni       in   1      asynchronous active-low reset
//     start_i      in   1      sweep request, honoured in IDLE/DONE with a legal mode
//     mode_i       in   3      reference function (0 AND .. 5 XNOR, 6/7 rejected)
//     dut_a_o      out  N_IN   vector driven into the gate under test (bit0 = A)
//     dut_x_i      in   1      gate under test output
//     busy_o       out  1      sweep in progress
//     done_o       out  1      sweep finished, held until the next accepted start
//     pass_o       out  1      with done_o: no mismatches seen
//     err_cnt_o    out  CNT_W  mismatch count, saturates at all-ones
//   Optional (macro GATE_SWEEP_FAILCAP_EN):
//     fail_valid_o out  1      a mismatch has been captured this sweep
//     fail_vec_o   out  N_IN   first mismatching vector of this sweep
module gate_sweep_checker
    import gate_sweep_pkg::*;
#(
    parameter int N_IN  = 2,
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [2:0]       mode_i,
    output logic [N_IN-1:0]  dut_a_o,
    input  logic             dut_x_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [CNT_W-1:0] err_cnt_o
`ifdef GATE_SWEEP_FAILCAP_EN
    ,
    output logic             fail_valid_o,
    output logic [N_IN-1:0]  fail_vec_o
`endif
);

    // A single-cycle dwell still needs a 1-bit counter to stay legal.
    localparam int               DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [N_IN-1:0]  VEC_LAST   = {N_IN{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [2:0]       mode_q,  mode_d;
    logic [N_IN-1:0]  vec_q,   vec_d;
    logic [DW_W-1:0]  dwell_q, dwell_d;
    logic [CNT_W-1:0] err_q,   err_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic             pass_q,  pass_d;
`ifdef GATE_SWEEP_FAILCAP_EN
    logic             fvalid_q, fvalid_d;
    logic [N_IN-1:0]  fvec_q,   fvec_d;
`endif

    logic             exp_bit;
    logic             mismatch;
    logic             start_ok;
    logic [CNT_W-1:0] err_inc;
    logic [CNT_W-1:0] err_next;

    gate_ref_model #(
        .N_IN (N_IN)
    ) u_ref (
        .mode_i (mode_q),
        .vec_i  (vec_q),
        .exp_o  (exp_bit)
    );

    assign mismatch = (dut_x_i != exp_bit);
    assign start_ok = start_i && (mode_i <= MODE_MAX);
    assign err_inc  = (err_q == CNT_MAX) ? err_q : (err_q + 1'b1);
    assign err_next = mismatch ? err_inc : err_q;

    // Next-state logic. The driven vector is the vec register itself, so it
    // naturally holds its last value through DONE until a new start.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        vec_d   = vec_q;
        dwell_d = dwell_q;
        err_d   = err_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
`ifdef GATE_SWEEP_FAILCAP_EN
        fvalid_d = fvalid_q;
        fvec_d   = fvec_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    state_d = ST_DRIVE;
                    mode_d  = mode_i;
                    vec_d   = '0;
                    dwell_d = '0;
                    err_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
`ifdef GATE_SWEEP_FAILCAP_EN
                    fvalid_d = 1'b0;
                    fvec_d   = '0;
`endif
                end
            end
            ST_DRIVE: begin
                if (dwell_q == DWELL_LAST) begin
                    state_d = ST_SAMPLE;
                    dwell_d = '0;
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            ST_SAMPLE: begin
                err_d = err_next;
`ifdef GATE_SWEEP_FAILCAP_EN
                if (mismatch && !fvalid_q) begin
                    fvalid_d = 1'b1;
                    fvec_d   = vec_q;
                end
`endif
                if (vec_q == VEC_LAST) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_next == '0);
                end else begin
                    state_d = ST_DRIVE;
                    vec_d   = vec_q + 1'b1;
                    dwell_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset drops any partial sweep immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_AND;
            vec_q   <= '0;
            dwell_q <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            vec_q   <= vec_d;
            dwell_q <= dwell_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

`ifdef GATE_SWEEP_FAILCAP_EN
    // First-failure capture registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fvalid_q <= 1'b0;
            fvec_q   <= '0;
        end else begin
            fvalid_q <= fvalid_d;
            fvec_q   <= fvec_d;
        end
    end

    assign fail_valid_o = fvalid_q;
    assign fail_vec_o   = fvec_q;
`endif

    assign dut_a_o   = vec_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign pass_o    = pass_q;
    assign err_cnt_o = err_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb_gate_sweep_checker
//   Drives gate_sweep_checker (N_IN=3, DWELL=3, CNT_W=3) against a behavioural
//   gate whose function and per-vector fault pattern are chosen by the bench.
//   Expected counts, pass and first-failure vector come from a popcount-based
//   model of the gate functions, evaluated over the whole vector space.
module tb_gate_sweep_checker;

    localparam int N     = 3;
    localparam int DW    = 3;
    localparam int CW    = 3;
    localparam int NVEC  = 1 << N;
    localparam int SWEEP = NVEC * (DW + 1);

    logic          clk = 1'b0;
    logic          rstN;
    logic          start;
    logic [2:0]    mode;
    logic [N-1:0]  dutA;
    logic          dutX;
    logic          busy;
    logic          done;
    logic          pass;
    logic [CW-1:0] errCnt;
`ifdef GATE_SWEEP_FAILCAP_EN
    logic          failValid;
    logic [N-1:0]  failVec;
`endif

    logic [2:0]      gateMode;
    logic [NVEC-1:0] faultMask;

    logic [CW-1:0] expErr;
    logic [N-1:0]  expFirst;
    logic          expAny;

    int vectorsApplied = 0;
    int miscompares    = 0;

    always #5 clk = ~clk;

    gate_sweep_checker #(
        .N_IN  (N),
        .DWELL (DW),
        .CNT_W (CW)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rstN),
        .start_i      (start),
        .mode_i       (mode),
        .dut_a_o      (dutA),
        .dut_x_i      (dutX),
        .busy_o       (busy),
        .done_o       (done),
        .pass_o       (pass),
        .err_cnt_o    (errCnt)
`ifdef GATE_SWEEP_FAILCAP_EN
        ,
        .fail_valid_o (failValid),
        .fail_vec_o   (failVec)
`endif
    );

    // Gate functions described by how many inputs are high.
    function automatic logic refBit(input logic [2:0] m, input logic [N-1:0] v);
        int ones;
        ones = $countones(v);
        case (m)
            3'd0:    return ones == N;
            3'd1:    return ones > 0;
            3'd2:    return ones != N;
            3'd3:    return ones == 0;
            3'd4:    return (ones % 2) == 1;
            3'd5:    return (ones % 2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    // Gate under test: a chosen function with optional per-vector faults.
    assign dutX = refBit(gateMode, dutA) ^ faultMask[dutA];

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorsApplied++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Whole-sweep expectation for reference mode m against the current gate.
    task automatic modelSweep(input logic [2:0] m);
        int n;
        n = 0;
        expAny   = 1'b0;
        expFirst = '0;
        for (int v = 0; v < NVEC; v++) begin
            if (refBit(m, N'(v)) != (refBit(gateMode, N'(v)) ^ faultMask[v])) begin
                if (!expAny) expFirst = N'(v);
                expAny = 1'b1;
                n++;
            end
        end
        expErr = (n > (1 << CW) - 1) ? CW'((1 << CW) - 1) : CW'(n);
    endtask

    task automatic checkFinal(input string tag);
        checkOutput({tag, "_flags"}, {30'd0, busy, done}, 32'b01);
        checkOutput({tag, "_err"},   32'(errCnt), 32'(expErr));
        checkOutput({tag, "_pass"},  32'(pass), 32'(expErr == '0));
        checkOutput({tag, "_dutA"},  32'(dutA), 32'(NVEC - 1));
`ifdef GATE_SWEEP_FAILCAP_EN
        checkOutput({tag, "_fvalid"}, 32'(failValid), 32'(expAny));
        checkOutput({tag, "_fvec"},   32'(failVec),   32'(expFirst));
`endif
    endtask

    // One full sweep, called shortly after a rising edge. Optionally pokes a
    // start mid-sweep, which must be ignored.
    task automatic applyStimulus(input logic [2:0] m, input bit poke);
        int pokeAt;
        pokeAt = $urandom_range(1, SWEEP - 1);
        modelSweep(m);
        start = 1'b1;
        mode  = m;
        @(posedge clk); #1;
        start = 1'b0;
        mode  = 3'($urandom_range(0, 7));
        checkOutput("accept", {28'd0, busy, done, errCnt == '0, dutA == '0}, 32'b1011);
        for (int e = 1; e <= SWEEP; e++) begin
            if (poke && e == pokeAt) begin
                start = 1'b1;
                mode  = 3'($urandom_range(0, 5));
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (e < SWEEP)
                checkOutput("sweep", 32'({busy, done, dutA}), 32'({1'b1, 1'b0, N'(e / (DW + 1))}));
        end
        checkFinal("done");
    endtask

    // Start with an illegal mode while done; everything must stay put.
    task automatic checkHold(input logic [2:0] m);
        start = 1'b1;
        mode  = m;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkFinal("hold");
    endtask

    initial begin
        rstN      = 1'b0;
        start     = 1'b0;
        mode      = 3'd0;
        gateMode  = 3'd2;
        faultMask = '0;
        #12;
        checkOutput("reset", 32'({busy, done, pass, errCnt, dutA}), 32'd0);
        @(posedge clk); #1;
        rstN = 1'b1;

        // Illegal mode in IDLE: nothing moves.
        start = 1'b1;
        mode  = 3'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("idleIllegal", 32'({busy, done, pass, errCnt, dutA}), 32'd0);

        // Directed: matching NAND, AND vs NAND (saturates), XOR vs NAND with a busy poke.
        gateMode = 3'd2;
        applyStimulus(3'd2, 1'b0);
        checkHold(3'd6);
        applyStimulus(3'd0, 1'b0);
        applyStimulus(3'd4, 1'b1);
        checkHold(3'd7);

        // Reset in the middle of vector 2 with errors already counted.
        gateMode = 3'd0;
        start = 1'b1;
        mode  = 3'd2;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2 * (DW + 1) + 1) @(posedge clk);
        #1;
        checkOutput("preReset", 32'({busy, dutA}), 32'({1'b1, N'(2)}));
        rstN = 1'b0;
        #1;
        checkOutput("midReset", 32'({busy, done, pass, errCnt, dutA}), 32'd0);
`ifdef GATE_SWEEP_FAILCAP_EN
        checkOutput("midResetCap", 32'({failValid, failVec}), 32'd0);
`endif
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetNoDone", 32'(done), 32'd0);
        rstN = 1'b1;
        gateMode = 3'd2;
        applyStimulus(3'd2, 1'b0);

        // Randomized sweeps against random gates and fault patterns.
        for (int i = 0; i < 16; i++) begin
            gateMode  = 3'($urandom_range(0, 5));
            faultMask = ($urandom_range(0, 1) == 1) ? NVEC'($urandom) : '0;
            applyStimulus(3'($urandom_range(0, 5)), bit'($urandom_range(0, 1)));
            if ((i % 4) == 3) checkHold(3'($urandom_range(6, 7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
